// File: rtl/ncl_pkg.sv
// Shared dual-rail helpers and FSM state type
// for the NCL operand injector.
package ncl_pkg;

  localparam logic [1:0] DR_NULL = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    NULL
  } ncl_state_t;

  // True rail on the high wire, false rail on the low wire.
  function automatic logic [1:0] dr_enc(input logic b);
    return {b, ~b};
  endfunction

  function automatic logic [7:0] dr_enc4(input logic [3:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[2*i +: 2] = dr_enc(v[i]);
    end
    return r;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for the asynchronous
// completion acknowledge.
module sincronizador_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/ncl_injetor_4bits.sv
// Binary-to-NCL four-phase injector: drives dual-rail
// DATA/NULL wavefronts into an adder stage.
module ncl_injetor_4bits
  import ncl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_a,
  input  logic [3:0]  in_b,
  input  logic        in_cin,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic [1:0]  opr,
  input  logic        ack,
  output logic        err,
  output logic [15:0] tokens
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

  ncl_state_t     state_q;
  logic [7:0]     a_q;
  logic [7:0]     b_q;
  logic [1:0]     opr_q;
  logic           err_q;
  logic [15:0]    tokens_q;
  logic [WDW-1:0] wd_q;
  logic [WDW-1:0] wd_d;
  logic           ack_s;

  sincronizador_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (ack),
    .q_o (ack_s)
  );

  assign wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;

  assign in_ready = (state_q == IDLE) && !ack_s && !rst;

  // Timeout only flags; the handshake keeps waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      opr_q    <= DR_NULL;
      err_q    <= 1'b0;
      tokens_q <= '0;
      wd_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          wd_q <= '0;
          if (in_valid && in_ready) begin
            a_q     <= dr_enc4(in_a);
            b_q     <= dr_enc4(in_b);
            opr_q   <= dr_enc(in_cin);
            state_q <= DATA;
          end
        end
        DATA: begin
          if (ack_s) begin
            a_q     <= '0;
            b_q     <= '0;
            opr_q   <= DR_NULL;
            wd_q    <= '0;
            state_q <= NULL;
          end else begin
            wd_q <= wd_d;
            if (wd_d == WD_MAX) err_q <= 1'b1;
          end
        end
        NULL: begin
          if (!ack_s) begin
            tokens_q <= tokens_q + 16'd1;
            wd_q     <= '0;
            state_q  <= IDLE;
          end else begin
            wd_q <= wd_d;
            if (wd_d == WD_MAX) err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign a      = a_q;
  assign b      = b_q;
  assign opr    = opr_q;
  assign err    = err_q;
  assign tokens = tokens_q;

endmodule

// File: tb/tb_ncl_injetor_4bits.sv
// Bench for ncl_injetor_4bits: phase-level model,
// per-cycle compare and directed scenarios.
module tb_ncl_injetor_4bits;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_a;
  logic [3:0]  in_b;
  logic        in_cin;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [1:0]  opr;
  logic        ack;
  logic        err;
  logic [15:0] tokens;

  always #5 clk = ~clk;

  ncl_injetor_4bits #(.TIMEOUT(T)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .a        (a),
    .b        (b),
    .opr      (opr),
    .ack      (ack),
    .err      (err),
    .tokens   (tokens)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dr4(input logic [3:0] v);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'd0;
    for (int i = 0; i < 4; i++) begin
      p = v[i] ? 8'd2 : 8'd1;
      r = r | (p << (2 * i));
    end
    return r;
  endfunction

  function automatic logic full(input logic [7:0] x,
                                input logic [7:0] y,
                                input logic [1:0] z);
    logic f;
    f = (z != 2'b00);
    for (int i = 0; i < 4; i++) begin
      if (x[2*i +: 2] == 2'b00 || y[2*i +: 2] == 2'b00) f = 1'b0;
    end
    return f;
  endfunction

  // Phase model: 0 idle, 1 data, 2 null; ack seen two edges late.
  int          m_ph  = 0;
  int          m_cnt = 0;
  logic [7:0]  m_a   = 8'd0;
  logic [7:0]  m_b   = 8'd0;
  logic [1:0]  m_o   = 2'd0;
  logic        m_err = 1'b0;
  logic [15:0] m_tok = 16'd0;
  logic [1:0]  m_ah  = 2'd0;
  logic        pre_req = 1'b0;
  logic        chk_en  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph  <= 0;
      m_cnt <= 0;
      m_a   <= 8'd0;
      m_b   <= 8'd0;
      m_o   <= 2'd0;
      m_err <= 1'b0;
      m_tok <= 16'd0;
      m_ah  <= 2'd0;
    end else begin
      m_ah <= {m_ah[0], ack};
      if (pre_req) m_tok <= 16'hFFFF;
      if (m_ph == 0) begin
        m_cnt <= 0;
        if (in_valid && !m_ah[1]) begin
          m_ph <= 1;
          m_a  <= dr4(in_a);
          m_b  <= dr4(in_b);
          m_o  <= in_cin ? 2'b10 : 2'b01;
        end
      end else if ((m_ph == 1 && m_ah[1]) || (m_ph == 2 && !m_ah[1])) begin
        m_cnt <= 0;
        if (m_ph == 1) begin
          m_ph <= 2;
          m_a  <= 8'd0;
          m_b  <= 8'd0;
          m_o  <= 2'd0;
        end else begin
          m_ph  <= 0;
          m_tok <= m_tok + 16'd1;
        end
      end else begin
        m_cnt <= (m_cnt < T) ? m_cnt + 1 : T;
        if (m_cnt + 1 >= T) m_err <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 32'(in_ready),
            32'(m_ph == 0 && !m_ah[1] && !rst));
      check("a", 32'(a), 32'(m_a));
      check("b", 32'(b), 32'(m_b));
      check("opr", 32'(opr), 32'(m_o));
      check("err", 32'(err), 32'(m_err));
      check("tokens", 32'(tokens), 32'(m_tok));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic b2b(input int n);
    int          done;
    int          k;
    logic        acc;
    logic [4:0]  q[$];
    logic [3:0]  da;
    logic [3:0]  db;
    logic [4:0]  s;
    done = 0;
    k = 0;
    in_a = 4'd0;
    in_b = 4'd0;
    in_cin = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 2000 && done < n; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) q.push_back(5'(in_a) + 5'(in_b) + 5'(in_cin));
      @(posedge clk);
      #1;
      if (acc) begin
        k++;
        in_a = 4'(k * 7);
        in_b = 4'(k * 11 + 3);
        in_cin = k[0];
      end
      if (!ack && full(a, b, opr)) begin
        for (int i = 0; i < 4; i++) begin
          da[i] = a[2*i+1];
          db[i] = b[2*i+1];
        end
        s = 5'(da) + 5'(db) + 5'(opr[1]);
        if (q.size() > 0) check("sum", 32'(s), 32'(q.pop_front()));
        else check("sum_queue", 32'(q.size()), 32'd1);
        ack = 1'b1;
      end else if (ack && a == 8'd0 && b == 8'd0 && opr == 2'd0) begin
        ack = 1'b0;
        done++;
      end
    end
    in_valid = 1'b0;
    check("b2b_done", 32'(done), 32'(n));
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = 4'd0;
    in_b = 4'd0;
    in_cin = 1'b0;
    ack = 1'b0;
    cyc(1);
    chk_en = 1'b1;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_a", 32'(a), 32'd0);
    cyc(1);
    rst = 1'b0;
    #1;
    check("rst_tokens", 32'(tokens), 32'd0);
    check("idle_ready", 32'(in_ready), 32'd1);

    // Single token 5 + 3.
    in_a = 4'h5;
    in_b = 4'h3;
    in_cin = 1'b0;
    in_valid = 1'b1;
    cyc(1);
    in_valid = 1'b0;
    check("t1_a", 32'(a), 32'h66);
    check("t1_b", 32'(b), 32'h5A);
    check("t1_opr", 32'(opr), 32'h1);
    in_a = 4'hF;
    in_b = 4'hC;
    in_cin = 1'b1;
    ack = 1'b1;
    cyc(2);
    check("t1_hold", 32'(a), 32'h66);
    cyc(1);
    check("t1_null_a", 32'(a), 32'h0);
    check("t1_null_opr", 32'(opr), 32'h0);
    ack = 1'b0;
    cyc(2);
    check("t1_tok_pre", 32'(tokens), 32'd0);
    cyc(1);
    check("t1_tok", 32'(tokens), 32'd1);

    // ack stuck high after reset.
    rst = 1'b1;
    ack = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(2);
    in_a = 4'h9;
    in_b = 4'h1;
    in_cin = 1'b0;
    in_valid = 1'b1;
    cyc(5);
    check("stuck_ready", 32'(in_ready), 32'd0);
    check("stuck_a", 32'(a), 32'd0);
    ack = 1'b0;
    cyc(3);
    in_valid = 1'b0;
    check("stuck_acc", 32'(a), 32'h96);
    ack = 1'b1;
    cyc(3);
    ack = 1'b0;
    cyc(3);
    check("stuck_tok", 32'(tokens), 32'd1);

    // Watchdog timeout with ack held low.
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    in_a = 4'hA;
    in_b = 4'h6;
    in_cin = 1'b1;
    in_valid = 1'b1;
    cyc(1);
    in_valid = 1'b0;
    cyc(7);
    check("to_err_pre", 32'(err), 32'd0);
    cyc(1);
    check("to_err", 32'(err), 32'd1);
    check("to_a", 32'(a), 32'h99);
    cyc(4);
    check("to_a_hold", 32'(a), 32'h99);
    ack = 1'b1;
    cyc(3);
    check("to_null", 32'(a), 32'd0);
    ack = 1'b0;
    cyc(3);
    check("to_tok", 32'(tokens), 32'd1);
    check("to_err_sticky", 32'(err), 32'd1);

    // Reset in the middle of DATA.
    in_a = 4'hF;
    in_b = 4'hF;
    in_cin = 1'b1;
    in_valid = 1'b1;
    cyc(1);
    in_valid = 1'b0;
    cyc(2);
    check("mid_data", 32'(a), 32'hAA);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    #1;
    check("mid_a", 32'(a), 32'd0);
    check("mid_b", 32'(b), 32'd0);
    check("mid_opr", 32'(opr), 32'd0);
    check("mid_tok", 32'(tokens), 32'd0);
    check("mid_idle", 32'(in_ready), 32'd1);

    // Back-to-back with an adder-stage model.
    b2b(20);
    cyc(4);
    check("b2b_tok", 32'(tokens), 32'd20);

    // Token counter wrap.
    chk_en = 1'b0;
    pre_req = 1'b1;
    force dut.tokens_q = 16'hFFFF;
    cyc(1);
    release dut.tokens_q;
    pre_req = 1'b0;
    chk_en = 1'b1;
    check("wrap_pre", 32'(tokens), 32'hFFFF);
    in_a = 4'h1;
    in_b = 4'h2;
    in_cin = 1'b0;
    in_valid = 1'b1;
    cyc(1);
    in_valid = 1'b0;
    ack = 1'b1;
    cyc(3);
    ack = 1'b0;
    cyc(2);
    check("wrap_hold", 32'(tokens), 32'hFFFF);
    cyc(1);
    check("wrap", 32'(tokens), 32'd0);

    cyc(2);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/ncl_injetor_4bits.md
NCL_INJETOR_4BITS -- requirements
Module: ncl_injetor_4bits

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 1023, meaning the maximum cycles to wait for an ack edge before flagging an error.
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, meaning reset; synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the binary operand token is valid.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts a token this cycle.
REQ-006 The block SHALL have ports in_a and in_b, input, 4 each, meaning the binary operands.
REQ-007 The block SHALL have port in_cin, input, 1, meaning the binary carry-in.
REQ-008 The block SHALL have ports a and b, output, 8 each, meaning the dual-rail operands for the NCL adder stage.
REQ-009 The block SHALL have port opr, output, 2, meaning the dual-rail carry-in.
REQ-010 The block SHALL have port ack, input, 1, meaning the asynchronous completion from the adder stage (1 = DATA latched, request NULL; 0 = NULL latched, request DATA).
REQ-011 The block SHALL have port err, output, 1, meaning a sticky handshake timeout.
REQ-012 The block SHALL have port tokens, output, 16, meaning the count of completed four-phase cycles.

Function
REQ-013 Dual-rail encoding SHALL be, for bit i: wire[2i+1] = true rail, wire[2i] = false rail; 01 = logic 0, 10 = logic 1, 00 = NULL; 11 SHALL never be driven.
REQ-014 opr SHALL use the same encoding: opr[1] = cin true, opr[0] = cin false.
REQ-015 a, b and opr SHALL be driven directly from flops: no glitches and no combinational path from any input.
REQ-016 ack SHALL pass through a 2-flop synchronizer before use (ack_s); the FSM SHALL see only ack_s.
REQ-017 The FSM SHALL have states IDLE, DATA and NULL.
REQ-018 IDLE: outputs NULL; in_ready = !ack_s; if in_valid && in_ready, the next edge SHALL register the encoded in_a/in_b/in_cin onto a/b/opr and enter DATA.
REQ-019 IDLE with ack_s = 1 SHALL hold in_ready low and wait.
REQ-020 DATA: outputs hold the DATA wavefront; in_ready = 0; ack_s = 1 SHALL cause the next edge to drive all outputs to NULL and enter NULL.
REQ-021 NULL: outputs NULL; in_ready = 0; ack_s = 0 SHALL cause the next edge to enter IDLE and increment tokens.
REQ-022 Minimum per-token cycle SHALL be 1 accept edge + ack rise seen through the synchronizer + ack fall seen through the synchronizer; the earliest next accept is in the IDLE cycle after return.
REQ-023 tokens SHALL wrap from 16'hFFFF to 0.
REQ-024 A watchdog counter SHALL clear on every state change and increment each cycle in DATA or NULL, saturating at TIMEOUT.
REQ-025 Reaching TIMEOUT SHALL set err, which stays set until reset; the FSM SHALL continue waiting and SHALL not abort.
REQ-026 The watchdog SHALL not count in IDLE.
REQ-027 Input operand changes outside an accept cycle SHALL have no effect on a, b or opr.

Reset
REQ-028 When rst = 1 at an edge, the block SHALL set state = IDLE, a = b = 8'h00, opr = 2'b00, err = 0, tokens = 0, watchdog = 0, and both synchronizer flops = 0.
REQ-029 Reset asserted mid-DATA SHALL drive NULL on the following edge, with no partial token counted.
REQ-030 in_ready SHALL be 0 while rst = 1.

Structure
REQ-031 A shared package ncl_pkg SHALL hold the dual-rail NULL constant, the bit-to-dual-rail encode function, and the FSM state typedef.
REQ-032 One sub-module, sincronizador_2ff (1-bit, clk/rst), SHALL implement the ack synchronizer.

Verification
REQ-033 Single token: in_a = 4'h5, in_b = 4'h3, in_cin = 0, accept -> a = 8'b01100110, b = 8'b01011010, opr = 2'b01; ack raised -> NULL 3 edges later; ack lowered -> tokens = 1.
REQ-034 Back-to-back: in_valid held high with a behavioral NCL adder+stage model for 20 tokens -> tokens = 20, and the sum of each operand pair matches the binary reference.
REQ-035 ack stuck high after reset: in_ready stays 0 and no token is accepted until ack falls.
REQ-036 Timeout: TIMEOUT = 8, ack never rises -> err = 1 after 8 DATA cycles, outputs remain DATA, and a later ack completes the token normally with err still 1.
REQ-037 Reset mid-token: rst pulsed during DATA -> next edge a = b = 0, opr = 0, tokens = 0, state IDLE.
REQ-038 Wrap: preload tokens to 16'hFFFF, complete one token -> tokens = 0.
